// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the elastic pipeline register.
//   WORD_WIDTH     : default payload width of the core datapath
//   ZeroWord       : all-zero word, the default reset payload
//   PIPE_MAX_DEPTH : largest supported number of register stages
//   slot_op_e      : per-slot command issued by the top-level control
package pipe_stage_reg_pkg;

  localparam int WORD_WIDTH     = 32;
  localparam int PIPE_MAX_DEPTH = 8;
  localparam logic [WORD_WIDTH-1:0] ZeroWord = 32'h0000_0000;

  // What a slot does at the next clock edge.
  typedef enum logic [1:0] {
    SLOT_HOLD  = 2'd0,  // keep valid bit and data
    SLOT_LOAD  = 2'd1,  // a valid entry moves in: capture data, set valid
    SLOT_DRAIN = 2'd2,  // the entry moves on with nothing replacing it
    SLOT_CLEAR = 2'd3   // flush: drop the entry, data left untouched
  } slot_op_e;

endpackage

// File: rtl/pipe_stage_slot.sv
// One pipeline slot: a valid flop plus a DATA_WIDTH data register.
// Used for every register stage and for the optional skid entry.
// Ports:
//   clk     : core clock
//   rst     : synchronous active-high reset (valid=0, data=RST_VAL)
//   op_i    : command for this edge (hold / load / drain / clear)
//   data_i  : payload captured on SLOT_LOAD
//   valid_o : slot holds a valid entry
//   data_o  : payload held by the slot
module pipe_stage_slot
  import pipe_stage_reg_pkg::*;
#(
  parameter int                    DATA_WIDTH = WORD_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = {DATA_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  slot_op_e              op_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;

  // Slot state: data changes only when a valid entry is loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= RST_VAL;
    end else begin
      case (op_i)
        SLOT_LOAD: begin
          valid_q <= 1'b1;
          data_q  <= data_i;
        end
        SLOT_DRAIN: valid_q <= 1'b0;
        SLOT_CLEAR: valid_q <= 1'b0;
        default:    valid_q <= valid_q;
      endcase
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register: DEPTH stages of payload + valid with a
// valid/ready handshake on both sides, stall, synchronous flush and bubble
// collapsing (an empty stage pulls from a valid predecessor even while the
// output is stalled).
//
// Optional feature, macro PIPE_SKID_EN:
//   defined   - a one-entry skid slot sits in front of stage 0; in_ready comes
//               from the skid valid flop, so out_ready has no combinational
//               path to in_ready; capacity DEPTH+1.
//   undefined - in_ready is combinational through the advance chain from
//               out_ready; capacity DEPTH.
//
// Ports:
//   clk        : core clock
//   rst        : synchronous active-high reset, priority over flush
//   flush      : synchronous kill of all in-flight entries (input dropped)
//   in_valid   : upstream offers in_data
//   in_ready   : block accepts in_data this cycle
//   in_data    : upstream payload
//   out_valid  : out_data holds a valid entry
//   out_ready  : downstream takes out_data this cycle
//   out_data   : payload of the last stage
//   occupancy  : number of valid entries held (skid included)
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                    DATA_WIDTH = WORD_WIDTH,
  parameter int                    DEPTH      = 1,
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = {DATA_WIDTH{1'b0}}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [$clog2(DEPTH+2)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 2);

  logic [DEPTH-1:0]      valid_s;
  logic [DATA_WIDTH-1:0] data_s [DEPTH];
  logic [DATA_WIDTH-1:0] din_s  [DEPTH];
  slot_op_e              op_s   [DEPTH];
  logic [DEPTH-1:0]      adv_s;
  logic [DEPTH-1:0]      load_s;
  logic                  s0_free_s;
  logic                  s0_load_s;
  logic [DATA_WIDTH-1:0] s0_din_s;
  logic                  in_fire_s;
  logic                  out_fire_s;
  logic [OCC_W-1:0]      occ_q;
  logic [OCC_W-1:0]      occ_d;

  // Advance chain, walked from the output back. 'blocked' means the stage
  // downstream of i can neither accept nor move on this cycle.
  always_comb begin
    logic blocked;
    adv_s   = {DEPTH{1'b0}};
    blocked = ~out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      adv_s[i] = valid_s[i] & ~blocked;
      blocked  = valid_s[i] & blocked;
    end
  end

  assign s0_free_s  = ~valid_s[0] | adv_s[0];
  assign in_fire_s  = in_valid & in_ready;
  assign out_fire_s = valid_s[DEPTH-1] & out_ready;

`ifdef PIPE_SKID_EN
  logic                  skid_valid_s;
  logic [DATA_WIDTH-1:0] skid_data_s;
  slot_op_e              skid_op_s;

  pipe_stage_slot #(
    .DATA_WIDTH (DATA_WIDTH),
    .RST_VAL    (RST_VAL)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .op_i    (skid_op_s),
    .data_i  (in_data),
    .valid_o (skid_valid_s),
    .data_o  (skid_data_s)
  );

  // Skid control: an input accepted while stage 0 is blocked parks here and
  // is drained into stage 0 ahead of any new input.
  always_comb begin
    skid_op_s = SLOT_HOLD;
    if (flush) begin
      skid_op_s = SLOT_CLEAR;
    end else if (in_fire_s && !s0_free_s) begin
      skid_op_s = SLOT_LOAD;
    end else if (skid_valid_s && s0_free_s) begin
      skid_op_s = SLOT_DRAIN;
    end else begin
      skid_op_s = SLOT_HOLD;
    end
  end

  assign in_ready  = ~rst & ~flush & ~skid_valid_s;
  assign s0_load_s = s0_free_s & (skid_valid_s | in_fire_s);
  assign s0_din_s  = skid_valid_s ? skid_data_s : in_data;
`else
  assign in_ready  = ~rst & ~flush & s0_free_s;
  assign s0_load_s = in_fire_s;
  assign s0_din_s  = in_data;
`endif

  // Per-stage commands: flush wins, then load from predecessor, then drain.
  always_comb begin
    load_s    = {DEPTH{1'b0}};
    load_s[0] = s0_load_s;
    din_s[0]  = s0_din_s;
    for (int i = 1; i < DEPTH; i++) begin
      load_s[i] = adv_s[i-1];
      din_s[i]  = data_s[i-1];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (flush) begin
        op_s[i] = SLOT_CLEAR;
      end else if (load_s[i]) begin
        op_s[i] = SLOT_LOAD;
      end else if (adv_s[i]) begin
        op_s[i] = SLOT_DRAIN;
      end else begin
        op_s[i] = SLOT_HOLD;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    pipe_stage_slot #(
      .DATA_WIDTH (DATA_WIDTH),
      .RST_VAL    (RST_VAL)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .op_i    (op_s[g]),
      .data_i  (din_s[g]),
      .valid_o (valid_s[g]),
      .data_o  (data_s[g])
    );
  end

  // Occupancy next value: net change of in/out transfers, zero on flush.
  always_comb begin
    if (flush) begin
      occ_d = {OCC_W{1'b0}};
    end else begin
      occ_d = occ_q + OCC_W'(in_fire_s) - OCC_W'(out_fire_s);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= {OCC_W{1'b0}};
    end else begin
      occ_q <= occ_d;
    end
  end

  assign out_valid = valid_s[DEPTH-1];
  assign out_data  = data_s[DEPTH-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
  localparam int DW = 32;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // DEPTH=3 instance
  logic          d3_flush, d3_in_valid, d3_in_ready, d3_out_valid, d3_out_ready;
  logic [DW-1:0] d3_in_data, d3_out_data;
  logic [2:0]    d3_occ;
  // DEPTH=2, RST_VAL=0xDEAD instance
  logic          d2_flush, d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready;
  logic [DW-1:0] d2_in_data, d2_out_data;
  logic [1:0]    d2_occ;
  // DEPTH=4 instance
  logic          d4_flush, d4_in_valid, d4_in_ready, d4_out_valid, d4_out_ready;
  logic [DW-1:0] d4_in_data, d4_out_data;
  logic [2:0]    d4_occ;

  pipe_stage_reg #(.DATA_WIDTH(DW), .DEPTH(3), .RST_VAL(32'h0)) u_d3 (
    .clk(clk), .rst(rst), .flush(d3_flush), .in_valid(d3_in_valid), .in_ready(d3_in_ready),
    .in_data(d3_in_data), .out_valid(d3_out_valid), .out_ready(d3_out_ready),
    .out_data(d3_out_data), .occupancy(d3_occ));

  pipe_stage_reg #(.DATA_WIDTH(DW), .DEPTH(2), .RST_VAL(32'hDEAD)) u_d2 (
    .clk(clk), .rst(rst), .flush(d2_flush), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
    .in_data(d2_in_data), .out_valid(d2_out_valid), .out_ready(d2_out_ready),
    .out_data(d2_out_data), .occupancy(d2_occ));

  pipe_stage_reg #(.DATA_WIDTH(DW), .DEPTH(4), .RST_VAL(32'h0)) u_d4 (
    .clk(clk), .rst(rst), .flush(d4_flush), .in_valid(d4_in_valid), .in_ready(d4_in_ready),
    .in_data(d4_in_data), .out_valid(d4_out_valid), .out_ready(d4_out_ready),
    .out_data(d4_out_data), .occupancy(d4_occ));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    d3_flush = 1'b0; d2_flush = 1'b0; d4_flush = 1'b0;
    d3_in_valid = 1'b1; d2_in_valid = 1'b0; d4_in_valid = 1'b0;
    d3_in_data = 32'h0; d2_in_data = 32'h0; d4_in_data = 32'h0;
    d3_out_ready = 1'b0; d2_out_ready = 1'b0; d4_out_ready = 1'b0;
    tick();
    tick();
    n_checks++;
    if (d3_in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready_low: got %b expected 0", d3_in_ready); end
    n_checks++;
    if (d2_out_data !== 32'hDEAD) begin n_errors++; $display("FAIL reset_rst_val: got %h expected 0000dead", d2_out_data); end
    n_checks++;
    if (d3_out_data !== 32'h0) begin n_errors++; $display("FAIL reset_data_d3: got %h expected 00000000", d3_out_data); end
    rst = 1'b0;
    d3_in_valid = 1'b0;
    #1;
    n_checks++;
    if ({d3_out_valid, d2_out_valid, d4_out_valid} !== 3'b000) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 000", {d3_out_valid, d2_out_valid, d4_out_valid}); end
    n_checks++;
    if ({d3_occ, d2_occ, d4_occ} !== 8'h00) begin n_errors++; $display("FAIL reset_occupancy: got %h expected 00", {d3_occ, d2_occ, d4_occ}); end
    n_checks++;
    if ({d3_in_ready, d2_in_ready, d4_in_ready} !== 3'b111) begin n_errors++; $display("FAIL reset_in_ready_after: got %b expected 111", {d3_in_ready, d2_in_ready, d4_in_ready}); end
  endtask

  // DEPTH=3 stream 1..16 with out_ready=1.
  task automatic test_stream();
    int sent;
    int got;
    sent = 0;
    got = 0;
    d3_out_ready = 1'b1;
    for (int c = 0; c < 40 && got < 16; c++) begin
      d3_in_valid = (sent < 16);
      d3_in_data  = DW'(sent + 1);
      #1;
      if (c < 3) begin
        n_checks++;
        if (d3_out_valid !== 1'b0) begin n_errors++; $display("FAIL stream_early_valid c=%0d: got %b expected 0", c, d3_out_valid); end
      end
      if (c == 3) begin
        n_checks++;
        if (d3_out_valid !== 1'b1) begin n_errors++; $display("FAIL stream_latency: got %b expected 1", d3_out_valid); end
      end
      if (c >= 3 && c <= 16) begin
        n_checks++;
        if (d3_occ !== 3'd3) begin n_errors++; $display("FAIL stream_occupancy c=%0d: got %0d expected 3", c, d3_occ); end
      end
      if (d3_in_valid) begin
        n_checks++;
        if (d3_in_ready !== 1'b1) begin n_errors++; $display("FAIL stream_in_ready c=%0d: got %b expected 1", c, d3_in_ready); end
      end
      if (d3_out_valid) begin
        n_checks++;
        if (d3_out_data !== DW'(got + 1)) begin n_errors++; $display("FAIL stream_order: got %h expected %h", d3_out_data, DW'(got + 1)); end
        got++;
      end
      if (d3_in_valid && d3_in_ready) sent++;
      tick();
    end
    d3_in_valid = 1'b0;
    n_checks++;
    if (got !== 16) begin n_errors++; $display("FAIL stream_count: got %0d expected 16", got); end
  endtask

  // DEPTH=2 back-pressure: A,B,C pushed against out_ready=0.
  task automatic test_backpressure();
    logic [DW-1:0] vals [3];
    logic [3:0]    exp_ready;
    int k;
    int got;
    vals[0] = 32'hA; vals[1] = 32'hB; vals[2] = 32'hC;
    exp_ready = {1'b0, SKID, 1'b1, 1'b1};
    k = 0;
    got = 0;
    d2_out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      d2_in_valid = (k < 3);
      d2_in_data  = vals[(k < 3) ? k : 2];
      #1;
      n_checks++;
      if (d2_in_ready !== exp_ready[c]) begin n_errors++; $display("FAIL bp_in_ready c=%0d: got %b expected %b", c, d2_in_ready, exp_ready[c]); end
      if (d2_in_valid && d2_in_ready) k++;
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (d2_out_valid !== 1'b1 || d2_out_data !== 32'hA) begin n_errors++; $display("FAIL bp_stall_hold c=%0d: got %b/%h expected 1/0000000a", c, d2_out_valid, d2_out_data); end
      n_checks++;
      if (d2_occ !== (SKID ? 2'd3 : 2'd2)) begin n_errors++; $display("FAIL bp_occupancy: got %0d expected %0d", d2_occ, SKID ? 3 : 2); end
      tick();
    end
    d2_out_ready = 1'b1;
    for (int c = 0; c < 12 && got < 3; c++) begin
      d2_in_valid = (k < 3);
      d2_in_data  = vals[(k < 3) ? k : 2];
      #1;
      if (d2_out_valid) begin
        n_checks++;
        if (d2_out_data !== vals[got]) begin n_errors++; $display("FAIL bp_release_order: got %h expected %h", d2_out_data, vals[got]); end
        got++;
      end
      if (d2_in_valid && d2_in_ready) k++;
      tick();
    end
    d2_in_valid = 1'b0;
    n_checks++;
    if (got !== 3) begin n_errors++; $display("FAIL bp_release_count: got %0d expected 3", got); end
  endtask

  // DEPTH=4 flush with three entries held and an input offered.
  task automatic test_flush();
    logic seen;
    int lat;
    d4_out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      d4_in_valid = 1'b1;
      d4_in_data  = DW'(32'h11 * (c + 1));
      tick();
    end
    d4_in_valid = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if (d4_out_data !== 32'h11 || d4_occ !== 3'd3) begin n_errors++; $display("FAIL flush_prefill: got %h/%0d expected 00000011/3", d4_out_data, d4_occ); end
    d4_flush    = 1'b1;
    d4_in_valid = 1'b1;
    d4_in_data  = 32'h44;
    #1;
    n_checks++;
    if (d4_in_ready !== 1'b0) begin n_errors++; $display("FAIL flush_in_ready: got %b expected 0", d4_in_ready); end
    tick();
    d4_flush    = 1'b0;
    d4_in_valid = 1'b0;
    #1;
    n_checks++;
    if (d4_out_valid !== 1'b0) begin n_errors++; $display("FAIL flush_out_valid: got %b expected 0", d4_out_valid); end
    n_checks++;
    if (d4_occ !== 3'd0) begin n_errors++; $display("FAIL flush_occupancy: got %0d expected 0", d4_occ); end
    n_checks++;
    if (d4_out_data !== 32'h11) begin n_errors++; $display("FAIL flush_data_kept: got %h expected 00000011", d4_out_data); end
    d4_out_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (d4_out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_errors++; $display("FAIL flush_dropped_input: got %b expected 0", seen); end
    d4_in_valid = 1'b1;
    d4_in_data  = 32'h55;
    tick();
    d4_in_valid = 1'b0;
    lat = 1;
    while (!d4_out_valid && lat < 10) begin
      tick();
      lat++;
    end
    n_checks++;
    if (lat !== 4 || d4_out_data !== 32'h55) begin n_errors++; $display("FAIL flush_resume: got lat %0d data %h expected lat 4 data 00000055", lat, d4_out_data); end
    tick();
  endtask

  // DEPTH=2 reset asserted mid-stream.
  task automatic test_reset_midstream();
    d2_out_ready = 1'b1;
    d2_in_valid  = 1'b1;
    d2_in_data   = 32'h1;
    tick();
    d2_in_data   = 32'h2;
    tick();
    d2_in_data   = 32'h3;
    rst          = 1'b1;
    #1;
    n_checks++;
    if (d2_in_ready !== 1'b0) begin n_errors++; $display("FAIL rst_mid_in_ready: got %b expected 0", d2_in_ready); end
    tick();
    rst         = 1'b0;
    d2_in_valid = 1'b0;
    #1;
    n_checks++;
    if (d2_out_valid !== 1'b0 || d2_out_data !== 32'hDEAD || d2_occ !== 2'd0) begin
      n_errors++; $display("FAIL rst_mid_state: got %b/%h/%0d expected 0/0000dead/0", d2_out_valid, d2_out_data, d2_occ);
    end
    d2_in_valid = 1'b1;
    d2_in_data  = 32'h77;
    #1;
    n_checks++;
    if (d2_in_ready !== 1'b1) begin n_errors++; $display("FAIL rst_mid_resume_ready: got %b expected 1", d2_in_ready); end
    tick();
    d2_in_valid = 1'b0;
    n_checks++;
    if (d2_out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_mid_resume_early: got %b expected 0", d2_out_valid); end
    tick();
    n_checks++;
    if (d2_out_valid !== 1'b1 || d2_out_data !== 32'h77) begin n_errors++; $display("FAIL rst_mid_resume_data: got %b/%h expected 1/00000077", d2_out_valid, d2_out_data); end
    tick();
  endtask

  // DEPTH=3 bubble collapse under a stalled output.
  task automatic test_bubble();
    d3_out_ready = 1'b0;
    d3_in_valid  = 1'b1;
    d3_in_data   = 32'h9;
    tick();
    d3_in_valid  = 1'b0;
    tick(); tick();
    n_checks++;
    if (d3_out_valid !== 1'b1 || d3_out_data !== 32'h9 || d3_occ !== 3'd1) begin
      n_errors++; $display("FAIL bubble_setup: got %b/%h/%0d expected 1/00000009/1", d3_out_valid, d3_out_data, d3_occ);
    end
    d3_in_valid = 1'b1;
    d3_in_data  = 32'h5;
    #1;
    n_checks++;
    if (d3_in_ready !== 1'b1) begin n_errors++; $display("FAIL bubble_ready0: got %b expected 1", d3_in_ready); end
    tick();
    d3_in_valid = 1'b0;
    #1;
    n_checks++;
    if (d3_in_ready !== 1'b1) begin n_errors++; $display("FAIL bubble_ready1: got %b expected 1", d3_in_ready); end
    tick();
    n_checks++;
    if (d3_occ !== 3'd2 || d3_out_data !== 32'h9) begin n_errors++; $display("FAIL bubble_hold: got %0d/%h expected 2/00000009", d3_occ, d3_out_data); end
    d3_out_ready = 1'b1;
    tick();
    n_checks++;
    if (d3_out_valid !== 1'b1 || d3_out_data !== 32'h5) begin n_errors++; $display("FAIL bubble_collapsed: got %b/%h expected 1/00000005", d3_out_valid, d3_out_data); end
    tick();
    n_checks++;
    if (d3_out_valid !== 1'b0) begin n_errors++; $display("FAIL bubble_drained: got %b expected 0", d3_out_valid); end
  endtask

  // DEPTH=3 random handshakes against a FIFO scoreboard.
  task automatic test_random();
    logic [DW-1:0] sb [$];
    logic [DW-1:0] next_val;
    logic [DW-1:0] prev_data;
    logic          prev_stall;
    next_val   = 32'h100;
    prev_stall = 1'b0;
    prev_data  = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      d3_in_valid  = 1'($urandom_range(0, 1));
      d3_in_data   = next_val;
      d3_out_ready = 1'($urandom_range(0, 1));
      #1;
      if (prev_stall) begin
        n_checks++;
        if (d3_out_valid !== 1'b1 || d3_out_data !== prev_data) begin n_errors++; $display("FAIL rand_stall_stable c=%0d: got %b/%h expected 1/%h", c, d3_out_valid, d3_out_data, prev_data); end
      end
      n_checks++;
      if (32'(d3_occ) !== 32'(sb.size())) begin n_errors++; $display("FAIL rand_occupancy c=%0d: got %0d expected %0d", c, d3_occ, sb.size()); end
      if (d3_out_valid && d3_out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++; $display("FAIL rand_spurious_out c=%0d: got %h expected nothing", c, d3_out_data);
        end else begin
          if (d3_out_data !== sb[0]) begin n_errors++; $display("FAIL rand_data c=%0d: got %h expected %h", c, d3_out_data, sb[0]); end
          void'(sb.pop_front());
        end
      end
      if (d3_in_valid && d3_in_ready) begin
        sb.push_back(d3_in_data);
        next_val = next_val + 32'h1;
      end
      prev_stall = d3_out_valid && !d3_out_ready;
      prev_data  = d3_out_data;
      tick();
    end
    d3_in_valid  = 1'b0;
    d3_out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (d3_out_valid) begin
        n_checks++;
        if (sb.size() == 0 || d3_out_data !== sb[0]) begin n_errors++; $display("FAIL rand_drain_data: got %h", d3_out_data); end
        if (sb.size() != 0) void'(sb.pop_front());
      end
      tick();
    end
    n_checks++;
    if (sb.size() != 0 || d3_occ !== 3'd0) begin n_errors++; $display("FAIL rand_drain_empty: got %0d left, occ %0d expected 0/0", sb.size(), d3_occ); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    test_bubble();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
